mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the bare PC register plus PC+4 adder of the single-cycle core. It holds the fetch PC and issues requests to an instruction memory of arbitrary, in-order latency. Fetched words are buffered in a small FIFO and delivered to decode with a valid/ready handshake. Decode drives redirects (branch/jump/jr); a redirect flushes wrong-path words.

Parameters:
ADDR_WIDTH, 32, width of all PC/address buses
RESET_PC, 32'h0040_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries; power of 2, >=2
MAX_OUTSTANDING, 2, max accepted-but-unanswered memory requests, >=1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  decode requests PC change this cycle
redirect_target  in  ADDR_WIDTH  new fetch/deliver PC
imem_req  out  1  fetch request
imem_addr  out  ADDR_WIDTH  word address of request (fetch_pc)
imem_gnt  in  1  request accepted when imem_req && imem_gnt
imem_rvalid  in  1  response valid, one per accepted request, in order, >=1 cycle after grant
imem_rdata  in  32  instruction word
inst_valid  out  1  FIFO non-empty
inst_ready  in  1  decode accepts word
inst_data  out  32  FIFO head word
inst_pc  out  ADDR_WIDTH  PC of head word
inst_pc_plus4  out  ADDR_WIDTH  inst_pc + 4, wraps modulo 2^ADDR_WIDTH
misaligned_err  out  1  sticky: redirect target low bits != 2'b00

Behaviour:
- Reset (async, active-high): fetch_pc = deliver_pc = RESET_PC, outstanding = drop_cnt = 0, FIFO empty, misaligned_err = 0.
- While reset is asserted: imem_req = 0, inst_valid = 0, imem_addr = inst_pc = RESET_PC.
- Reset mid-operation: all in-flight state is discarded. The instruction memory is reset on the same signal.
- Issue rule (combinational):
  - imem_req = !redirect_valid && !misaligned_err && (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH).
  - These credits guarantee the FIFO never overflows; push-on-full is unreachable and is asserted against.
- On grant: fetch_pc += 4 (wraps) and outstanding += 1.
- On imem_rvalid: outstanding -= 1 (grant and rvalid in the same cycle leave it unchanged).
  - If drop_cnt > 0: the word is discarded and drop_cnt -= 1.
  - Otherwise imem_rdata is pushed into the FIFO.
- Latency: rvalid in cycle N gives inst_valid=1 in N+1 (registered FIFO, no bypass). Minimum redirect-to-first-instruction is 3 cycles with a 1-cycle memory.
- Delivery: a word is consumed on inst_valid && inst_ready, and deliver_pc += 4. Push and pop in the same cycle are legal, including on a full-minus-one FIFO.
- Redirect cycle, aligned target (all ordered):
  - A handshake in the same cycle still completes, so the branch itself is consumed.
  - The FIFO is then flushed and fetch_pc = deliver_pc = redirect_target.
  - drop_cnt = outstanding − (imem_rvalid ? 1 : 0). Any response arriving in that cycle is discarded.
  - imem_req is 0 in that cycle.
- Redirect with target[1:0] != 0:
  - The FIFO is flushed and misaligned_err is set, sticky until reset.
  - imem_req stays 0 from then on; outstanding responses drain and are dropped; inst_valid stays 0.
- Back-to-back redirects: the latest wins. drop_cnt is recomputed from the current outstanding count each time.
- No state machine beyond RUN/HALT(err); HALT is entered only via a misaligned redirect and left only via reset.

Decomposition:
- Package mips_fetch_pkg:
  - INSTR_WIDTH=32, PC_INCREMENT=4, DEFAULT_RESET_PC=32'h0040_0000.
  - NOP=32'h0000_0000, the word driven on inst_data when empty.
  - A function clog2 for counter widths.
- One sub-module: instr_fifo.
  - Synchronous FIFO, parameters WIDTH/DEPTH, ports push/pop/flush/data.
  - Outputs count/empty; flush has priority over push.
  - Sits on clk with the same async reset.
- PC tracking and credit logic live in mips_fetch_unit. Per-entry PCs are not stored; inst_pc is deliver_pc.

Test Plan:
1. Reset release, 1-cycle memory, gnt=1, inst_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, ...; first inst_valid with inst_pc=0x00400000 and inst_pc_plus4=0x00400004; throughput 1/cycle.
2. inst_ready=0 for 10 cycles, FIFO_DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 words buffered; imem_req drops to 0; no overflow; release gives in-order PCs with no gaps.
3. Redirect to 0x00400100 with 2 requests outstanding -> both late responses dropped; next delivered inst_pc=0x00400100 with the matching word; no stale word visible.
4. Redirect to 0x00400102 -> misaligned_err=1; imem_req=0 forever; inst_valid=0; reset clears error and fetch resumes at RESET_PC.
5. fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=0x00000000; inst_pc_plus4 of that word is 0x00000000.
6. Reset asserted asynchronously mid-burst, 3-cycle memory latency -> outputs go to reset values without a clock edge; after release the first inst_pc=0x00400000.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
//   INSTR_WIDTH      : width of an instruction word
//   PC_INCREMENT     : byte distance between sequential instructions
//   DEFAULT_RESET_PC : first fetch address after reset
//   NOP              : word presented on inst_data while the buffer is empty
//   fetchState_t     : RUN while fetching, HALT after a misaligned redirect
//   clog2            : ceiling log2, used for counter and pointer widths
package mips_fetch_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam int          PC_INCREMENT     = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetchState_t;

    // Smallest r with 2**r >= value; written as a bounded loop so it
    // evaluates cleanly as a constant function.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction buffer with registered storage (no bypass).
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push       : write pushData this cycle
//   pop        : remove the head entry this cycle (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   headData   : current head entry (undefined content when empty)
//   count      : number of stored entries
//   empty      : no entries stored
module instr_fifo
    import mips_fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      headData,
    output logic [clog2(DEPTH):0] count,
    output logic                  empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign doPush   = push && !flush;
    assign doPop    = pop && !empty && !flush;
    assign headData = mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // The fetch unit's credit scheme must never let a write land on a full
    // buffer unless the head leaves in the same cycle.
    assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues requests to an
// in-order instruction memory of arbitrary latency, buffers returned words
// and hands them to decode with a valid/ready handshake.
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   redirect_valid/_target : decode-driven PC change; flushes wrong-path words
//   imem_req/_addr/_gnt    : request channel, accepted on req && gnt
//   imem_rvalid/_rdata     : in-order responses, one per accepted request
//   inst_valid/_ready      : delivery handshake to decode
//   inst_data/_pc/_pc_plus4: head word, its PC and the sequential successor
//   misaligned_err         : sticky flag after a redirect to a non-word target
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INSTR_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0]  inst_pc,
    output logic [ADDR_WIDTH-1:0]  inst_pc_plus4,
    output logic                   misaligned_err
);

    localparam int OUT_W  = clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W = clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W  = ((OUT_W > FCNT_W) ? OUT_W : FCNT_W) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCREMENT);

    fetchState_t            stateQ;
    fetchState_t            stateD;
    logic [ADDR_WIDTH-1:0]  fetchPc;
    logic [ADDR_WIDTH-1:0]  deliverPc;
    logic [OUT_W-1:0]       outstanding;
    logic [OUT_W-1:0]       dropCnt;

    logic [INSTR_WIDTH-1:0] fifoHead;
    logic [FCNT_W-1:0]      fifoCount;
    logic                   fifoEmpty;
    logic [SUM_W-1:0]       inFlight;

    logic                   grant;
    logic                   pushWord;
    logic                   popWord;
    logic                   redirectOk;
    logic                   redirectBad;

    assign redirectOk  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redirectBad = redirect_valid && (redirect_target[1:0] != 2'b00);

    // Words already requested plus words already buffered may not exceed
    // the buffer size, so every response always has a slot waiting.
    assign inFlight = SUM_W'(outstanding) + SUM_W'(fifoCount);

    // Reset gates the request directly: with async reset the counters are
    // already cleared and would otherwise raise a request during reset.
    assign imem_req = !reset && !redirect_valid && (stateQ == RUN)
                   && (outstanding < OUT_W'(MAX_OUTSTANDING))
                   && (inFlight < SUM_W'(FIFO_DEPTH));
    assign imem_addr = fetchPc;
    assign grant     = imem_req && imem_gnt;

    // Responses from before the latest redirect are counted off by dropCnt;
    // a response coinciding with a redirect is wrong-path by definition.
    assign pushWord = imem_rvalid && (dropCnt == '0) && !redirect_valid
                   && (stateQ == RUN);
    assign popWord  = inst_valid && inst_ready;

    assign inst_valid     = !fifoEmpty;
    assign inst_data      = fifoEmpty ? NOP : fifoHead;
    assign inst_pc        = deliverPc;
    assign inst_pc_plus4  = deliverPc + PC_STEP;
    assign misaligned_err = (stateQ == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (redirectBad) begin
            stateD = HALT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            deliverPc   <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(grant) - OUT_W'(imem_rvalid);

            if (redirect_valid) begin
                dropCnt <= outstanding - OUT_W'(imem_rvalid);
            end else if (imem_rvalid && (dropCnt != '0)) begin
                dropCnt <= dropCnt - 1'b1;
            end

            if (redirectOk) begin
                fetchPc <= redirect_target;
            end else if (grant) begin
                fetchPc <= fetchPc + PC_STEP;
            end

            // A handshake in the redirect cycle still retires the branch;
            // the target then overrides the advanced deliver PC.
            if (redirectOk) begin
                deliverPc <= redirect_target;
            end else if (popWord) begin
                deliverPc <= deliverPc + PC_STEP;
            end
        end
    end

    instr_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pushWord),
        .pushData (imem_rdata),
        .pop      (popWord),
        .flush    (redirect_valid),
        .headData (fifoHead),
        .count    (fifoCount),
        .empty    (fifoEmpty)
    );

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        misaligned_err;

    mips_fetch_unit #(
        .ADDR_WIDTH      (32),
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_pc_plus4   (inst_pc_plus4),
        .misaligned_err  (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] memAddr;
        logic [31:0] expAddr;
        bit          stale;
        int unsigned ready;
    } req_t;

    req_t        memQ[$];
    logic [31:0] bufQ[$];
    logic [31:0] expFetch;
    bit          expErr;
    int unsigned cycle;
    int          latMin;
    int          latMax;
    int          errors;
    int          checks;

    bit          lastPop;
    logic [31:0] lastPopPc;
    logic [31:0] lastPopPlus4;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic modelReset();
        memQ.delete();
        bufQ.delete();
        expFetch = RPC;
        expErr   = 1'b0;
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic step(input bit rdv, input logic [31:0] tgt, input bit rdy, input bit gntIn);
        bit   rsp;
        bit   expReq;
        bit   expValid;
        bit   grantS;
        bit   popS;
        req_t head;
        int   lat;
        logic [31:0] sampAddr;

        redirect_valid  = rdv;
        redirect_target = tgt;
        inst_ready      = rdy;
        imem_gnt        = gntIn;
        rsp = (memQ.size() > 0) && (memQ[0].ready <= cycle);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? memWord(memQ[0].memAddr) : $urandom;
        #1;
        expReq = !rdv && !expErr && (memQ.size() < MAXO)
              && (memQ.size() + bufQ.size() < DEPTH);
        expValid = (bufQ.size() > 0);

        checks++;
        if (imem_req !== expReq) begin
            errors++;
            $display("FAIL imem_req cyc=%0d: got %b expected %b", cycle, imem_req, expReq);
        end
        if (expReq) begin
            checks++;
            if (imem_addr !== expFetch) begin
                errors++;
                $display("FAIL imem_addr cyc=%0d: got %h expected %h", cycle, imem_addr, expFetch);
            end
        end
        checks++;
        if (inst_valid !== expValid) begin
            errors++;
            $display("FAIL inst_valid cyc=%0d: got %b expected %b", cycle, inst_valid, expValid);
        end
        if (expValid) begin
            checks++;
            if (inst_pc !== bufQ[0]) begin
                errors++;
                $display("FAIL inst_pc cyc=%0d: got %h expected %h", cycle, inst_pc, bufQ[0]);
            end
            checks++;
            if (inst_pc_plus4 !== bufQ[0] + 32'd4) begin
                errors++;
                $display("FAIL inst_pc_plus4 cyc=%0d: got %h expected %h", cycle, inst_pc_plus4, bufQ[0] + 32'd4);
            end
            checks++;
            if (inst_data !== memWord(bufQ[0])) begin
                errors++;
                $display("FAIL inst_data cyc=%0d: got %h expected %h", cycle, inst_data, memWord(bufQ[0]));
            end
        end
        checks++;
        if (misaligned_err !== expErr) begin
            errors++;
            $display("FAIL misaligned_err cyc=%0d: got %b expected %b", cycle, misaligned_err, expErr);
        end

        grantS       = (imem_req === 1'b1) && gntIn;
        popS         = (inst_valid === 1'b1) && rdy;
        sampAddr     = imem_addr;
        lastPop      = popS;
        lastPopPc    = inst_pc;
        lastPopPlus4 = inst_pc_plus4;

        @(posedge clk);
        if (popS && bufQ.size() > 0) begin
            void'(bufQ.pop_front());
        end
        if (rsp) begin
            head = memQ.pop_front();
            if (!head.stale && !rdv && !expErr) begin
                bufQ.push_back(head.expAddr);
            end
        end
        if (grantS) begin
            lat = $urandom_range(latMax, latMin);
            memQ.push_back('{sampAddr, expFetch, 1'b0, cycle + lat});
            expFetch = expFetch + 32'd4;
        end
        if (rdv) begin
            bufQ.delete();
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            if (tgt[1:0] != 2'b00) expErr = 1'b1;
            else expFetch = tgt;
        end
        cycle++;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic doReset();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        inst_ready     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", inst_valid);
        end
        checks++;
        if (imem_addr !== RPC) begin
            errors++;
            $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC);
        end
        checks++;
        if (inst_pc !== RPC) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", inst_pc, RPC);
        end
        checks++;
        if (misaligned_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", misaligned_err);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic waitFirstPop(input string name, input logic [31:0] expPc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (lastPop) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: no delivery within 40 cycles, expected pc %h", name, expPc);
        end else if (lastPopPc !== expPc) begin
            errors++;
            $display("FAIL %s: got pc %h expected %h", name, lastPopPc, expPc);
        end
    endtask

    task automatic test_reset();
        latMin = 1; latMax = 1;
        doReset();
    endtask

    task automatic test_stream();
        int pops;
        pops = 0;
        latMin = 1; latMax = 1;
        doReset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (lastPop) begin
                if (pops == 0) begin
                    checks++;
                    if (lastPopPc !== RPC || lastPopPlus4 !== RPC + 32'd4) begin
                        errors++;
                        $display("FAIL stream_first: got %h/%h expected %h/%h", lastPopPc, lastPopPlus4, RPC, RPC + 32'd4);
                    end
                end
                pops++;
            end
        end
        checks++;
        if (pops < 17) begin
            errors++;
            $display("FAIL stream_throughput: got %0d pops expected at least 17", pops);
        end
    endtask

    task automatic test_backpressure();
        int pops;
        pops = 0;
        latMin = 1; latMax = 1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (lastPop) pops++;
        end
        checks++;
        if (pops != DEPTH) begin
            errors++;
            $display("FAIL backpressure_buffered: got %0d words expected %0d", pops, DEPTH);
        end
    endtask

    task automatic test_redirect();
        bit hit;
        hit = 1'b0;
        latMin = 2; latMax = 2;
        doReset();
        for (int i = 0; i < 30 && !hit; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (i > 4 && memQ.size() == 2) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL redirect_setup: got %0d outstanding expected 2", memQ.size());
        end
        step(1'b1, 32'h0040_0100, 1'b1, 1'b1);
        waitFirstPop("redirect_first", 32'h0040_0100);
    endtask

    task automatic test_misaligned();
        latMin = 1; latMax = 3;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0040_0102, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        checks++;
        if (misaligned_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_halt: got err=%b req=%b valid=%b expected 1/0/0", misaligned_err, imem_req, inst_valid);
        end
        doReset();
        waitFirstPop("misaligned_recover", RPC);
    endtask

    task automatic test_wrap();
        bit sawWrap;
        sawWrap = 1'b0;
        latMin = 1; latMax = 1;
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (lastPop && lastPopPc == 32'hFFFF_FFFC) begin
                sawWrap = 1'b1;
                checks++;
                if (lastPopPlus4 !== 32'h0000_0000) begin
                    errors++;
                    $display("FAIL wrap_plus4: got %h expected 00000000", lastPopPlus4);
                end
            end
        end
        checks++;
        if (!sawWrap) begin
            errors++;
            $display("FAIL wrap_seen: got no delivery of pc fffffffc expected one");
        end
    endtask

    task automatic test_async_reset();
        latMin = 3; latMax = 3;
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        doReset();
        waitFirstPop("async_reset_first", RPC);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit          rdv;
        latMin = 1; latMax = 4;
        doReset();
        for (int i = 0; i < 400; i++) begin
            rdv = ($urandom_range(15, 0) == 0);
            tgt = RPC + ($urandom_range(255, 0) << 2);
            if ($urandom_range(99, 0) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
            step(rdv, tgt, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0));
            if (expErr && $urandom_range(7, 0) == 0) doReset();
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        cycle           = 0;
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        inst_ready      = 1'b0;
        modelReset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
